// File: rtl/mvau_stream_pkg.sv
// Shared types and helpers for the MVAU weight streamer.
package mvau_stream_pkg;

  // Controller states: waiting for a job, issuing reads, emptying the pipe.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stream_state_e;

  // Entries in the output skid FIFO.
  localparam int unsigned FIFO_DEPTH = 2;

  // True when one more read can be issued without the FIFO ever overflowing:
  // words already stored plus the word in flight, minus the word leaving now,
  // must leave a free slot.
  function automatic logic fifo_has_room(input logic [1:0] occupancy,
                                         input logic       inflight,
                                         input logic       pop);
    return ({1'b0, occupancy} + {2'b00, inflight}) < (3'(FIFO_DEPTH) + {2'b00, pop});
  endfunction

endpackage

// File: rtl/mvau_skid_fifo2.sv
// Two-entry register FIFO; the head entry drives the output stream directly.
module mvau_skid_fifo2 #(
  parameter int unsigned DW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_valid,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          do_pop;

  // Next-state for storage, pointers and occupancy; push and pop together keep the count.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Register update with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two data entries are cleared too so the head (and m_axis_tdata) reads 0 out of reset.
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/mvau_weight_streamer.sv
// Streams NUM_REPS passes of a WMEM_DEPTH-word weight memory onto an AXI-Stream
// port, issuing reads only when the skid FIFO is guaranteed to have room.
module mvau_weight_streamer
  import mvau_stream_pkg::*;
#(
  parameter int unsigned SIMD         = 2,
  parameter int unsigned TW           = 1,
  parameter int unsigned WMEM_DEPTH   = 4,
  parameter int unsigned WMEM_ADDR_BW = 4,
  parameter int unsigned NUM_REPS     = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_rd_data,
  output logic [SIMD*TW-1:0]      m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int unsigned WORD_W  = SIMD * TW;
  localparam int unsigned FIFO_W  = WORD_W + 1;
  localparam int unsigned PASS_BW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;

  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [PASS_BW-1:0]      LAST_PASS = PASS_BW'(NUM_REPS - 1);

  stream_state_e           state_q, state_d;
  logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
  logic [PASS_BW-1:0]      pass_q, pass_d;
  logic                    inflight_q, inflight_d;
  logic                    last_tag_q, last_tag_d;
  logic                    done_q, done_d;

  logic                    issue;
  logic                    pop;
  logic [1:0]              fifo_count;
  logic                    fifo_valid;
  logic [FIFO_W-1:0]       fifo_head;

  // Controller: job start, read issue with address/pass stepping, and drain to done.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    pop        = fifo_valid && m_axis_tready;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          addr_d  = '0;
          pass_d  = '0;
        end
      end
      RUN: begin
        if (fifo_has_room(fifo_count, inflight_q, pop)) begin
          issue = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + 1'b1;
            if (pass_q == LAST_PASS) state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!fifo_valid && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The memory answers one cycle after the issue; the tag rides alongside.
    inflight_d = issue;
    last_tag_d = issue && (addr_q == LAST_ADDR);
  end

  // Controller registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
      last_tag_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      inflight_q <= inflight_d;
      last_tag_q <= last_tag_d;
      done_q     <= done_d;
    end
  end

  mvau_skid_fifo2 #(
    .DW (FIFO_W)
  ) u_fifo (
    .clk        (aclk),
    .rst_n      (aresetn),
    .push       (inflight_q),
    .push_data  ({last_tag_q, wmem_rd_data}),
    .pop        (pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign wmem_addr     = addr_q;
  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tdata  = fifo_head[WORD_W-1:0];
  assign m_axis_tlast  = fifo_head[FIFO_W-1];

endmodule

// File: tb/tb_mvau_weight_streamer.sv
// Scoreboard bench for mvau_weight_streamer with a one-cycle registered memory model.
module tb_mvau_weight_streamer;

  localparam int SIMD      = 2;
  localparam int TW        = 1;
  localparam int DEPTH     = 4;
  localparam int ABW       = 4;
  localparam int REPS      = 2;
  localparam int DW        = SIMD * TW;
  localparam int JOB_WORDS = DEPTH * REPS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic           aclk    = 1'b0;
  logic           aresetn = 1'b0;
  logic           start   = 1'b0;
  logic           tready  = 1'b0;
  logic           busy, done, tvalid, tlast;
  logic [ABW-1:0] wmem_addr;
  logic [DW-1:0]  rd_data;
  logic [DW-1:0]  tdata;
  logic [DW-1:0]  mem [DEPTH];

  int    checks        = 0;
  int    errors        = 0;
  int    job_words     = 0;
  int    job_lasts     = 0;
  int    done_count    = 0;
  int    dones_wanted  = 0;
  int    tready_mode   = 0;  // 0 high, 1 toggle, 2 random, 3 low
  word_t exp_q[$];

  mvau_weight_streamer #(
    .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW), .NUM_REPS(REPS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .wmem_addr     (wmem_addr),
    .wmem_rd_data  (rd_data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  always #5 aclk = ~aclk;

  // Weight memory: one-cycle registered read.
  always @(posedge aclk) begin
    if (wmem_addr < ABW'(DEPTH)) rd_data <= mem[wmem_addr[1:0]];
    else                         rd_data <= '0;
  end

  // Downstream ready pattern, changed just after each rising edge.
  always @(posedge aclk) begin
    #1;
    case (tready_mode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      2:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: a job is NUM_REPS full sweeps of the memory, last word of each sweep tagged.
  task automatic push_job();
    word_t w;
    for (int r = 0; r < REPS; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w.data = mem[a];
        w.last = (a == DEPTH - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stall stability and job completion.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge aclk) begin : monitor
    word_t w;
    if (aresetn) begin
      if (prev_stall) begin
        check("stall_tvalid", 32'(tvalid), 32'd1);
        check("stall_tdata", 32'(tdata), 32'(prev_data));
        check("stall_tlast", 32'(tlast), 32'(prev_last));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h with nothing expected (t=%0t)", tdata, $time);
        end else begin
          w = exp_q.pop_front();
          check("tdata", 32'(tdata), 32'(w.data));
          check("tlast", 32'(tlast), 32'(w.last));
        end
        job_words++;
        if (tlast) job_lasts++;
      end
      if (done) begin
        done_count++;
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_word_count", 32'(job_words), 32'(JOB_WORDS));
        check("done_tlast_count", 32'(job_lasts), 32'(REPS));
        check("done_busy_low", 32'(busy), 32'd0);
        job_words = 0;
        job_lasts = 0;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // FIFO occupancy bound.
  always @(negedge aclk) begin
    if (aresetn) begin
      checks++;
      assert (dut.u_fifo.count_q <= 2'd2)
      else begin
        errors++;
        $display("FAIL fifo_occupancy: got %0d, limit 2 (t=%0t)", dut.u_fifo.count_q, $time);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(tlast), 32'd0);
    check({tag, "_tdata"}, 32'(tdata), 32'd0);
    check({tag, "_wmem_addr"}, 32'(wmem_addr), 32'd0);
  endtask

  // Raise start now, let the next edge take it, and measure first-tvalid latency.
  task automatic start_now();
    int k;
    start = 1'b1;
    push_job();
    @(posedge aclk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (!tvalid && k < 10) begin
      @(posedge aclk);
      #1;
      k++;
    end
    check("first_tvalid_latency", 32'(k), 32'd2);
  endtask

  task automatic start_job();
    @(posedge aclk);
    #1;
    start_now();
  endtask

  // Wait (bounded) for done, drop start as soon as it is seen, then confirm a one-cycle pulse.
  task automatic wait_done(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge aclk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    dones_wanted++;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", max_cycles);
    end else begin
      @(negedge aclk);
      check("done_pulse_width", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    // Full-rate streaming: eight words on consecutive cycles.
    @(negedge aclk);
    tready_mode = 0;
    start_job();
    for (int i = 0; i < JOB_WORDS; i++) begin
      check("stream_back_to_back", 32'(tvalid), 32'd1);
      @(posedge aclk);
      #1;
    end
    wait_done(50);

    // Alternating ready.
    @(negedge aclk);
    tready_mode = 1;
    start_job();
    wait_done(100);

    // Ready held low: reads stop with the FIFO full at address 2.
    @(negedge aclk);
    tready_mode = 3;
    start_job();
    repeat (8) @(posedge aclk);
    #1;
    check("stall_wmem_addr", 32'(wmem_addr), 32'd2);
    check("stall_occupancy", 32'(dut.u_fifo.count_q), 32'd2);
    @(negedge aclk);
    tready_mode = 0;
    wait_done(100);

    // Start held for a whole job: exactly one job.
    @(posedge aclk);
    #1;
    start = 1'b1;
    push_job();
    wait_done(100);
    repeat (20) @(negedge aclk);
    check("held_start_idle", 32'(busy), 32'd0);
    check("held_start_no_extra", 32'(exp_q.size()), 32'd0);

    // Second pulse while busy is ignored; a fresh start after done runs again.
    start_job();
    @(posedge aclk);
    #1;
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    wait_done(100);
    start_job();
    wait_done(100);

    // Reset after the third word, then restart on the first edge after release.
    @(negedge aclk);
    tready_mode = 0;
    start_job();
    for (int i = 0; i < 50 && job_words < 3; i++) begin
      @(negedge aclk);
      #1;
    end
    check("reached_third_word", 32'(job_words >= 3), 32'd1);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    exp_q.delete();
    job_words = 0;
    job_lasts = 0;
    repeat (2) @(negedge aclk);
    #1;
    aresetn = 1'b1;
    start_now();
    wait_done(100);

    // Random memory contents with random ready.
    for (int j = 0; j < 4; j++) begin
      @(negedge aclk);
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      tready_mode = 2;
      start_job();
      wait_done(200);
    end

    @(negedge aclk);
    tready_mode = 0;
    repeat (5) @(negedge aclk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_count), 32'(dones_wanted));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
